tnn_feature_loader: RTL and testbench

//   Front end for the generated TNN classifier cores. Accepts one B-bit feature per

---
 rtl/tnn_pkg.sv | 43 ++++
 rtl/tnn_feature_loader_if.sv | 35 +++
 rtl/tnn_feature_loader.sv | 109 ++++++++++
 tb/tb_tnn_feature_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// Shared types and width helpers for the TNN classifier front end.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: loader FSM state enum, default parameter values, clog2-based
// width helpers and the feature-slot offset helper used to pack cls_inp.
package tnn_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    OUT    = 2'd2
  } state_t;

  localparam int N_DEF  = 11;
  localparam int B_DEF  = 4;
  localparam int C_DEF  = 7;
  localparam int TS_DEF = 5;
  localparam int CW_DEF = 16;

  // clog2 clamped to 1 so degenerate parameters still give a legal vector width.
  function automatic int cnt_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int klass_w(input int c);
    return cnt_w(c);
  endfunction

  function automatic int idx_w(input int n);
    return cnt_w(n);
  endfunction

  // The timer must be able to hold Ts-1; sized from Ts+1 to match the classifier wrapper.
  function automatic int timer_w(input int ts);
    return cnt_w(ts + 1);
  endfunction

  // Feature 0 sits in the most significant slot of the flat classifier bus.
  function automatic int slot_lsb(input int k, input int n, input int b);
    return (n - 1 - k) * b;
  endfunction

endpackage

// File: rtl/tnn_feature_loader_if.sv
// Handshake and data bundle between the feature loader and its environment.
// Latency: n/a (wiring only).
// Backpressure: s_ready throttles the feature stream, m_ready throttles results.
// slave  : the loader side (consumes features, drives the classifier bus and results).
// master : the environment side (feature producer, classifier core, result consumer).
interface tnn_feature_loader_if #(
  parameter int N  = 11,
  parameter int B  = 4,
  parameter int KW = 3,
  parameter int CW = 16
);

  logic             s_valid;
  logic             s_ready;
  logic [B-1:0]     s_data;
  logic             s_last;
  logic [N*B-1:0]   cls_inp;
  logic [KW-1:0]    cls_klass;
  logic             m_valid;
  logic             m_ready;
  logic [KW-1:0]    m_klass;
  logic             m_err;
  logic [CW-1:0]    vec_count;

  modport slave (
    input  s_valid, s_data, s_last, cls_klass, m_ready,
    output s_ready, cls_inp, m_valid, m_klass, m_err, vec_count
  );

  modport master (
    output s_valid, s_data, s_last, cls_klass, m_ready,
    input  s_ready, cls_inp, m_valid, m_klass, m_err, vec_count
  );

endinterface

// File: rtl/tnn_feature_loader.sv
// Packs N B-bit feature beats into the classifier's flat bus, waits Ts settle cycles, samples the class index.
// Latency: m_valid rises exactly Ts clocks after the edge accepting the final beat of a vector.
// Backpressure: s_ready is low outside LOAD; the result is held until m_ready, then the bus clears.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   bus.s_*    : feature stream in (valid/ready, data, last)
//   bus.cls_*  : flat feature bus to the classifier, class index back from it
//   bus.m_*    : result out (valid/ready, class index, framing error)
//   bus.vec_count : completed result handshakes, wraps modulo 2^CW
module tnn_feature_loader
  import tnn_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int B  = B_DEF,
  parameter int C  = C_DEF,
  parameter int Ts = TS_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  tnn_feature_loader_if.slave bus
);

  localparam int KW = klass_w(C);
  localparam int IW = idx_w(N);
  localparam int TW = timer_w(Ts);
  localparam int LW = cnt_w(N * B);

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [TW-1:0]   r_timer;
  logic [N*B-1:0]  r_cls_inp;
  logic            r_m_valid;
  logic [KW-1:0]   r_m_klass;
  logic            r_m_err;
  logic [CW-1:0]   r_vec_count;

  logic            w_s_ready;
  logic            w_acc;
  logic            w_idx_full;
  logic [LW-1:0]   w_lsb;

  // s_ready is gated by rst directly so nothing is taken during the reset cycle itself.
  assign w_s_ready  = (r_state == LOAD) & ~rst;
  assign w_acc      = bus.s_valid & w_s_ready;
  assign w_idx_full = (r_idx == IW'(N - 1));
  assign w_lsb      = LW'(slot_lsb(int'(r_idx), N, B));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_idx       <= '0;
      r_timer     <= '0;
      r_cls_inp   <= '0;
      r_m_valid   <= 1'b0;
      r_m_klass   <= '0;
      r_m_err     <= 1'b0;
      r_vec_count <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_acc) begin
            r_cls_inp[w_lsb +: B] <= bus.s_data;
            // A vector ends on s_last or on the N-th beat, whichever comes first;
            // either mismatch is a framing error but the vector is still classified.
            if (bus.s_last || w_idx_full) begin
              r_state <= SETTLE;
              r_idx   <= '0;
              r_timer <= '0;
              r_m_err <= ~w_idx_full | ~bus.s_last;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

        SETTLE: begin
          if (r_timer == TW'(Ts - 1)) begin
            r_m_klass <= bus.cls_klass;
            r_m_valid <= 1'b1;
            r_state   <= OUT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        OUT: begin
          // Clearing cls_inp here means an early-terminated next vector sees zeros in unwritten slots.
          if (r_m_valid && bus.m_ready) begin
            r_m_valid   <= 1'b0;
            r_cls_inp   <= '0;
            r_vec_count <= r_vec_count + 1'b1;
            r_state     <= LOAD;
          end
        end

        default: r_state <= LOAD;
      endcase
    end
  end

  assign bus.s_ready   = w_s_ready;
  assign bus.cls_inp   = r_cls_inp;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_klass   = r_m_klass;
  assign bus.m_err     = r_m_err;
  assign bus.vec_count = r_vec_count;

endmodule

// File: tb/tb_tnn_feature_loader.sv
// Directed bench for tnn_feature_loader (N=11, B=4, Ts=5, classifier stubbed by a driven klass).
// A second instance with CW=2 shares all inputs to observe counter wrap.
module tb_tnn_feature_loader;
  import tnn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tnn_feature_loader_if #(.N(11), .B(4), .KW(3), .CW(16)) bus ();
  tnn_feature_loader_if #(.N(11), .B(4), .KW(3), .CW(2))  bus2 ();

  tnn_feature_loader #(.N(11), .B(4), .C(7), .Ts(5), .CW(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  tnn_feature_loader #(.N(11), .B(4), .C(7), .Ts(5), .CW(2)) u_dut_cw2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  assign bus2.s_valid   = bus.s_valid;
  assign bus2.s_data    = bus.s_data;
  assign bus2.s_last    = bus.s_last;
  assign bus2.cls_klass = bus.cls_klass;
  assign bus2.m_ready   = bus.m_ready;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cyc = 0;
  int hs_cyc  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; holds the beat until an edge with s_ready high takes it.
  task automatic send_beat(input logic [3:0] d, input logic l);
    logic got;
    int   t;
    got = 1'b0;
    t   = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    while (!got && t < 200) begin
      @(negedge clk);
      got = bus.s_ready;
      @(posedge clk);
      #1;
      t++;
    end
    acc_cyc = cyc;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (!got) chk("beat_accept_timeout", 64'(got), 64'd1);
  endtask

  task automatic send_vec(input logic [43:0] v);
    for (int k = 0; k < 11; k++)
      send_beat(v[(10-k)*4 +: 4], (k == 10));
  endtask

  // Returns at a negedge with m_valid high; lat counts edges since the last accepted beat.
  task automatic wait_result(output int lat);
    logic seen;
    int   t;
    seen = 1'b0;
    t    = 0;
    while (!seen && t < 100) begin
      @(negedge clk);
      seen = bus.m_valid;
      t++;
    end
    lat = cyc - acc_cyc;
    if (!seen) chk("result_timeout", 64'(seen), 64'd1);
  endtask

  task automatic take_result;
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    bus.m_ready = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [43:0] mkvec(input int v);
    logic [43:0] r;
    r = '0;
    for (int k = 0; k < 11; k++)
      r[(10-k)*4 +: 4] = 4'((v * 3 + k) % 16);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

  initial begin
    int   lat;
    int   bad;
    logic seen;

    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.s_last    = 1'b0;
    bus.m_ready   = 1'b0;
    bus.cls_klass = '0;
    rst           = 1'b1;

    // Reset state, sampled while rst is still high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready",   64'(bus.s_ready),   64'd0);
    chk("rst_m_valid",   64'(bus.m_valid),   64'd0);
    chk("rst_cls_inp",   64'(bus.cls_inp),   64'd0);
    chk("rst_vec_count", 64'(bus.vec_count), 64'd0);
    chk("rst_m_klass",   64'(bus.m_klass),   64'd0);
    chk("rst_m_err",     64'(bus.m_err),     64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", 64'(bus.s_ready), 64'd1);
    @(posedge clk);
    #1;

    // 1: clean vector 1..B.
    bus.cls_klass = 3'd3;
    send_vec(44'h123456789AB);
    chk("t1_cls_inp_settle", 64'(bus.cls_inp), 64'h123456789AB);
    wait_result(lat);
    chk("t1_latency", 64'(lat),         64'd5);
    chk("t1_m_klass", 64'(bus.m_klass), 64'd3);
    chk("t1_m_err",   64'(bus.m_err),   64'd0);
    take_result();
    chk("t1_m_valid_clr", 64'(bus.m_valid),   64'd0);
    chk("t1_cls_inp_clr", 64'(bus.cls_inp),   64'd0);
    chk("t1_vec_count",   64'(bus.vec_count), 64'd1);

    // 2: result held 20 cycles under backpressure; a pending beat must not be taken.
    send_vec(44'h123456789AB);
    wait_result(lat);
    chk("t2_latency", 64'(lat), 64'd5);
    bus.s_valid   = 1'b1;
    bus.s_data    = 4'h9;
    bus.s_last    = 1'b1;
    bus.cls_klass = 3'd6;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.m_valid !== 1'b1 || bus.m_klass !== 3'd3 ||
          bus.cls_inp !== 44'h123456789AB || bus.s_ready !== 1'b0)
        bad++;
    end
    chk("t2_hold_bad_cycles", 64'(bad), 64'd0);
    take_result();
    chk("t2_vec_count", 64'(bus.vec_count), 64'd2);
    send_beat(4'h9, 1'b1);
    chk("t2_pending_accept_delay", 64'(acc_cyc - hs_cyc), 64'd1);
    wait_result(lat);
    chk("t2_single_cls_inp", 64'(bus.cls_inp), 64'h90000000000);
    chk("t2_single_m_err",   64'(bus.m_err),   64'd1);
    chk("t2_single_m_klass", 64'(bus.m_klass), 64'd6);
    take_result();

    // 3: early s_last after three beats; klass changes late in the settle window.
    bus.cls_klass = 3'd2;
    send_beat(4'hF, 1'b0);
    send_beat(4'hF, 1'b0);
    send_beat(4'hF, 1'b1);
    chk("t3_cls_inp", 64'(bus.cls_inp), 64'hFFF00000000);
    repeat (4) @(posedge clk);
    #1;
    bus.cls_klass = 3'd5;
    wait_result(lat);
    chk("t3_latency", 64'(lat),         64'd5);
    chk("t3_m_klass", 64'(bus.m_klass), 64'd5);
    chk("t3_m_err",   64'(bus.m_err),   64'd1);
    take_result();

    // 4: missing s_last; the 12th beat waits and opens the next vector.
    bus.cls_klass = 3'd1;
    for (int k = 0; k < 11; k++) send_beat(4'h5, 1'b0);
    chk("t4_cls_inp", 64'(bus.cls_inp), 64'h55555555555);
    bus.s_valid = 1'b1;
    bus.s_data  = 4'h7;
    bus.s_last  = 1'b1;
    wait_result(lat);
    chk("t4_latency", 64'(lat),         64'd5);
    chk("t4_m_err",   64'(bus.m_err),   64'd1);
    chk("t4_s_ready", 64'(bus.s_ready), 64'd0);
    take_result();
    send_beat(4'h7, 1'b1);
    chk("t4_next_accept_delay", 64'(acc_cyc - hs_cyc), 64'd1);
    wait_result(lat);
    chk("t4_next_cls_inp", 64'(bus.cls_inp), 64'h70000000000);
    chk("t4_next_m_err",   64'(bus.m_err),   64'd1);
    take_result();
    chk("t4_vec_count", 64'(bus.vec_count), 64'd6);

    // 5: reset pulse on the second settle cycle abandons the vector.
    bus.cls_klass = 3'd3;
    send_vec(44'h123456789AB);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_m_valid",   64'(bus.m_valid),   64'd0);
    chk("t5_cls_inp",   64'(bus.cls_inp),   64'd0);
    chk("t5_vec_count", 64'(bus.vec_count), 64'd0);
    chk("t5_m_klass",   64'(bus.m_klass),   64'd0);
    chk("t5_m_err",     64'(bus.m_err),     64'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | bus.m_valid;
    end
    chk("t5_no_result", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    bus.cls_klass = 3'd4;
    send_vec(44'hFEDCBA98765);
    wait_result(lat);
    chk("t5_latency", 64'(lat),         64'd5);
    chk("t5_cls_inp_ok", 64'(bus.cls_inp), 64'hFEDCBA98765);
    chk("t5_m_klass", 64'(bus.m_klass), 64'd4);
    chk("t5_m_err_ok", 64'(bus.m_err),  64'd0);
    take_result();
    chk("t5_vec_count_ok", 64'(bus.vec_count), 64'd1);

    // 6: five back-to-back vectors, consumer always ready; CW=2 copy wraps.
    do_reset();
    bus.cls_klass = 3'd2;
    bus.m_ready   = 1'b1;
    fork
      begin
        for (int v = 0; v < 5; v++) send_vec(mkvec(v));
      end
      begin
        for (int i = 0; i < 5; i++) begin
          logic vs;
          int   t;
          vs = 1'b0;
          t  = 0;
          while (!vs && t < 200) begin
            @(negedge clk);
            vs = bus.m_valid;
            t++;
          end
          if (!vs) chk("t6_result_timeout", 64'(vs), 64'd1);
          chk($sformatf("t6_cls_inp_%0d", i), 64'(bus.cls_inp), 64'(mkvec(i)));
          chk($sformatf("t6_m_err_%0d", i),   64'(bus.m_err),   64'd0);
          @(posedge clk);
          #1;
          chk($sformatf("t6_vec_count_cw2_%0d", i), 64'(bus2.vec_count), 64'((i + 1) % 4));
          chk($sformatf("t6_vec_count_%0d", i),     64'(bus.vec_count),  64'(i + 1));
        end
      end
    join
    bus.m_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
